// File: rtl/lc3_mem_pkg.sv
// Shared types for the LC3 data-memory access stage: op classes, state encoding
// (shared with the controller and its golden model) and the idle bus address.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'd0,
    OP_STORE     = 2'd1,
    OP_LOAD_IND  = 2'd2,
    OP_STORE_IND = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_IND   = 2'd1,
    ST_WRITE = 2'd2,
    ST_IDLE  = 2'd3
  } mem_state_t;

  localparam logic [15:0] MEM_IDLE_ADDR = 16'h0000;

  // First memory phase for a freshly accepted op.
  function automatic mem_state_t first_state(input mem_op_t op);
    case (op)
      OP_LOAD:  first_state = ST_READ;
      OP_STORE: first_state = ST_WRITE;
      default:  first_state = ST_IND;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_timer.sv
// Per-phase wait counter; expired flags the last allowed cycle of a memory phase.
module lc3_mem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)         cnt_d = '0;
    else if (count_en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_mem_sequencer.sv
// LC3 memory stage: sequences LD/ST and indirect LDI/STI over a handshaked
// data memory, with a per-phase timeout. All outputs are registered.
module lc3_mem_sequencer
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [15:0] M_addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] Data_dout,
  input  logic        complete_data,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  output logic        Data_rd,
  output logic [15:0] memout,
  output logic [1:0]  mem_state,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  mem_state_t  state_q;
  mem_op_t     op_q, op_d;
  logic [15:0] addr_q, data_q, ind_q;
  logic [15:0] daddr_q, ddin_q, memout_q;
  logic        drd_q, busy_q, done_q, terr_q;

  logic expired, abort, tmr_clear, use_ind;

  assign op_d      = mem_op_t'(mem_op);
  assign abort     = (state_q != ST_IDLE) && !complete_data && expired;
  assign tmr_clear = (state_q == ST_IDLE) || complete_data || expired;
  // Second phase of an indirect op addresses the pointer fetched in IND.
  assign use_ind   = (state_q != ST_IND) && (op_q inside {OP_LOAD_IND, OP_STORE_IND});

  lc3_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmr_clear),
    .count_en (!complete_data),
    .expired  (expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      addr_q   <= '0;
      data_q   <= '0;
      ind_q    <= '0;
      daddr_q  <= MEM_IDLE_ADDR;
      ddin_q   <= '0;
      memout_q <= '0;
      drd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          drd_q <= 1'b1;
          if (start) begin
            op_q    <= op_d;
            addr_q  <= M_addr;
            data_q  <= M_Data;
            terr_q  <= 1'b0;
            busy_q  <= 1'b1;
            daddr_q <= M_addr;
            state_q <= first_state(op_d);
            if (op_d == OP_STORE) begin
              drd_q  <= 1'b0;
              ddin_q <= M_Data;
            end
          end
        end
        ST_IND: begin
          daddr_q <= addr_q;
          if (complete_data) begin
            ind_q   <= Data_dout;
            daddr_q <= Data_dout;
            if (op_q == OP_STORE_IND) begin
              state_q <= ST_WRITE;
              drd_q   <= 1'b0;
              ddin_q  <= data_q;
            end else begin
              state_q <= ST_READ;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          daddr_q <= use_ind ? ind_q : addr_q;
          if (complete_data) begin
            if (state_q == ST_READ) memout_q <= Data_dout;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            drd_q   <= 1'b1;
          end
        end
      endcase
      // Abort overrides any phase that ran out of wait budget.
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        drd_q   <= 1'b1;
        terr_q  <= 1'b1;
      end
    end
  end

  assign Data_addr   = daddr_q;
  assign Data_din    = ddin_q;
  assign Data_rd     = drd_q;
  assign memout      = memout_q;
  assign mem_state   = state_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: doc/lc3_mem_sequencer.md
# lc3_mem_sequencer

Multi-cycle data-memory access stage of the LC3 pipeline. It sits between Execute, which supplies `M_addr`, `M_Data` and the memory-op class, and Writeback, which consumes `memout`. It sequences LD/LDR, ST/STR, LDI and STI accesses over a ready-handshaked data memory. It drives `mem_state` to the controller and raises `done` when the access retires.

## Interface
Parameters:
- `TIMEOUT`, default 16: cycles one memory phase may wait for `complete_data` before it is aborted.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately.
- `start`  in  1  controller request; sampled only in IDLE.
- `mem_op`  in  2  `mem_op_t`: LOAD=0, STORE=1, LOAD_IND=2, STORE_IND=3.
- `M_addr`  in  16  effective address from Execute.
- `M_Data`  in  16  store data from Execute.
- `Data_dout`  in  16  read data from data memory.
- `complete_data`  in  1  memory phase done: read data valid, or write accepted.
- `Data_addr`  out  16  memory address.
- `Data_din`  out  16  memory write data.
- `Data_rd`  out  1  1 = read, 0 = write.
- `memout`  out  16  load result to Writeback.
- `mem_state`  out  2  READ=0, IND=1, WRITE=2, IDLE=3.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle retire pulse.
- `timeout_err`  out  1  sticky abort flag.

## Operation
- Reset values:
  - `mem_state` = IDLE (3).
  - `Data_addr`, `Data_din`, `memout` = 16'h0000.
  - `Data_rd` = 1.
  - `busy`, `done`, `timeout_err` = 0.
  - Internal address, data, op and indirect-address registers = 0.
- IDLE:
  - Outputs idle: `Data_rd`=1, `Data_addr` holds its last value.
  - When `start`=1, latch `mem_op`, `M_addr` and `M_Data`, and clear `timeout_err`.
  - Next state: LOAD→READ, STORE→WRITE, LOAD_IND or STORE_IND→IND.
- IND:
  - `Data_addr` = latched addr, `Data_rd` = 1.
  - On `complete_data`, latch `Data_dout` into ind_addr.
  - Then go to READ (LOAD_IND) or WRITE (STORE_IND).
- READ:
  - `Data_addr` = ind_addr for LOAD_IND, otherwise the latched addr. `Data_rd` = 1.
  - On `complete_data`: `memout` ← `Data_dout`, pulse `done`, go to IDLE.
- WRITE:
  - `Data_addr` = ind_addr for STORE_IND, otherwise the latched addr.
  - `Data_din` = latched data, `Data_rd` = 0.
  - On `complete_data`: pulse `done`, go to IDLE.
- Timeout:
  - The phase counter clears on every state entry and increments each cycle that `complete_data` is 0.
  - When it reaches `TIMEOUT`-1 without a completion: set `timeout_err`, pulse `done`, go to IDLE.
  - An aborted access leaves `memout` unchanged.
- `start` in any state other than IDLE is ignored. No queueing; the controller must hold off until `busy`=0.
- `complete_data` sampled in IDLE is ignored, including in the same cycle as `start`.
- Reset mid-operation aborts the access immediately. No `done` is produced, and `memout` returns to 0.
- Addresses are used as-is. 16'hFFFF is legal and there is no wrap logic.

## Timing
- All outputs are registered.
- `done` and the new `memout` appear together, one cycle after the edge that samples the final `complete_data`.
- Minimum latency, `start` sampled at edge k to `done` high:
  - LOAD / STORE: edge k+2.
  - LOAD_IND / STORE_IND: edge k+3.
- Each cycle of memory wait adds one cycle.
- `busy` rises at edge k+1 and falls at the same edge `done` rises. Back-to-back `start` is therefore accepted at the edge where `done` is high.
- `mem_state` changes on the same edge as the internal state.

## Structure
- Package `lc3_mem_pkg`:
  - `mem_op_t` enum.
  - `mem_state_t` enum with the fixed encoding above (READ=0, IND=1, WRITE=2, IDLE=3); the controller and its golden model share this encoding.
  - Constant `MEM_IDLE_ADDR` = 16'h0000.
- Sub-module `lc3_mem_timer`: phase counter with `clear`, `count_en` and `expired`, sized $clog2(`TIMEOUT`).

## Test plan
- LOAD: `M_addr`=16'h3005, memory returns 16'hBEEF with `complete_data` in the first READ cycle → `Data_rd`=1, `Data_addr`=3005, `done` at k+2, `memout`=BEEF, `mem_state` sequence 3,0,3.
- STORE_IND: addr 16'h4000, indirect word 16'h4100, data 16'h1234 → IND reads 4000; WRITE drives `Data_addr`=4100, `Data_din`=1234, `Data_rd`=0; `done` at k+3; `mem_state` 3,1,2,3.
- LOAD_IND with 3 wait cycles per phase → `done` at k+9, `memout` = second-read data, `busy` high for 8 cycles.
- `TIMEOUT`=16, `complete_data` held 0 in READ → `timeout_err`=1 and `done` pulse after 16 READ cycles, `memout` unchanged. The next `start` clears `timeout_err`.
- `start` pulsed while `busy` → ignored: a single `done`, latched addr unchanged.
- `reset` driven low in the middle of the IND phase → outputs return to their reset values immediately, with no `done`. After release, a fresh LOAD completes normally.
